// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, result and flags out,
// each direction with its own valid/ready handshake.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             InValid;
  logic             InReady;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Carry;

  modport master (
    output InValid, ALUOp, A, B, OutReady,
    input  InReady, OutValid, Result, Zero, Carry
  );

  modport slave (
    input  InValid, ALUOp, A, B, OutReady,
    output InReady, OutValid, Result, Zero, Carry
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with IDLE/DONE handshake FSM. Defining ALU_SEQ_MUL_EN adds opcode 1010,
// a shift-add multiply that runs WIDTH cycles in an extra BUSY state.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     CLK,
  input  logic     Reset,
  alu_seq_if.slave bus
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [3:0]     MUL_OP   = 4'b1010;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  // Bit WIDTH of the return value is the carry/borrow flag.
  function automatic logic [WIDTH:0] alu_fn(input logic [3:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = {(WIDTH+1){1'b0}};
    case (op)
      4'b0000: r = {1'b0, a} + {1'b0, b};
      4'b0001: r = {1'b0, a | b};
      4'b0010: r = {1'b0, a & b};
      4'b0011: r = {{WIDTH{1'b0}}, (b > a)};
      4'b0100: r = {{WIDTH{1'b0}}, (b == a)};
      4'b0101: r = {{WIDTH{1'b0}}, (b != a)};
      4'b0110: r = (a >= WIDTH_V) ? {(WIDTH+1){1'b0}} : {1'b0, b >> a};
      4'b0111: r = (a >= WIDTH_V) ? {(WIDTH+1){1'b0}} : {1'b0, b << a};
      4'b1000: r = {1'b0, ~b};
      4'b1001: r = {1'b0, a} - {1'b0, b};
      default: r = {(WIDTH+1){1'b0}};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH:0]   alu_res_s;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  assign alu_res_s = alu_fn(bus.ALUOp, bus.A, bus.B);

  // Next-state and next-output logic for the handshake FSM and multiplier datapath.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
`ifdef ALU_SEQ_MUL_EN
          if (bus.ALUOp == MUL_OP) begin
            state_d  = BUSY;
            mcand_d  = bus.A;
            mplier_d = bus.B;
            acc_d    = ZERO_W;
            cnt_d    = CNT_ZERO;
          end else begin
            state_d  = DONE;
            result_d = alu_res_s[WIDTH-1:0];
            carry_d  = alu_res_s[WIDTH];
            zero_d   = (alu_res_s[WIDTH-1:0] == ZERO_W);
          end
`else
          state_d  = DONE;
          result_d = alu_res_s[WIDTH-1:0];
          carry_d  = alu_res_s[WIDTH];
          zero_d   = (alu_res_s[WIDTH-1:0] == ZERO_W);
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      // One multiplier bit per cycle; bits shifted past WIDTH are dropped.
      BUSY: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : ZERO_W);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = acc_d;
          zero_d   = (acc_d == ZERO_W);
          carry_d  = 1'b0;
        end else begin
          state_d = BUSY;
        end
      end
`endif
      DONE: begin
        if (bus.OutReady) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, result flags and handshake outputs, all registered; Reset wins over everything.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      result_q    <= ZERO_W;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= ZERO_W;
      mplier_q    <= ZERO_W;
      acc_q       <= ZERO_W;
      cnt_q       <= CNT_ZERO;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = out_valid_q;
  assign bus.Result   = result_q;
  assign bus.Zero     = zero_q;
  assign bus.Carry    = carry_q;

endmodule
